// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample player.
package audio_pkg;

  localparam int unsigned MEM_ADDR_W     = 19;
  localparam int unsigned SAMPLE_W       = 8;
  // 50 MHz system clock / 16 kHz sample rate
  localparam int unsigned DEF_SAMPLE_DIV = 3125;

  typedef logic [MEM_ADDR_W-1:0] addr_t;
  typedef logic [SAMPLE_W-1:0]   sample_t;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StFetch,
    StWait,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/audio_sample_player_if.sv
// Memory read port between the sample player and the IO controller.
interface audio_sample_player_if;
  import audio_pkg::*;

  logic    audio_req;
  addr_t   audio_addr;
  sample_t mem_data;
  logic    data_ready;

  modport master (
    output audio_req,
    output audio_addr,
    input  mem_data,
    input  data_ready
  );

  modport slave (
    input  audio_req,
    input  audio_addr,
    output mem_data,
    output data_ready
  );

endinterface

// File: rtl/pwm_dac.sv
// 8-bit PWM DAC: free-running period counter, duty reloaded only at period boundaries.
module pwm_dac
  import audio_pkg::*;
#(
  parameter sample_t IDLE_LEVEL = 8'h80
) (
  input  logic    clk,
  input  logic    clr,
  input  sample_t sample,
  output logic    pwm
);

  logic [SAMPLE_W-1:0] pc_q;
  sample_t             duty_q;

  // Reload on the last count so every period (pc 0..255) uses a single duty value.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q   <= '0;
      duty_q <= IDLE_LEVEL;
    end else begin
      pc_q <= pc_q + SAMPLE_W'(1);
      if (pc_q == '1) begin
        duty_q <= sample;
      end
    end
  end

  assign pwm = (pc_q < duty_q);

endmodule

// File: rtl/audio_sample_player.sv
// Streams PCM samples from shared memory at a fixed rate into a PWM DAC.
module audio_sample_player
  import audio_pkg::*;
#(
  parameter addr_t       BASE_ADDR  = 19'd3,
  parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter sample_t     IDLE_LEVEL = 8'h80
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         start,
  input  addr_t                        stopPos,
  audio_sample_player_if.master        mem,
  output logic                         audio_done,
  output logic                         audio_pwm,
  output logic                         audio_en,
  output logic                         underrun
);

  localparam int unsigned   DivW    = $clog2(SAMPLE_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(SAMPLE_DIV - 1);

  state_e          state_q;
  addr_t           stop_q;
  addr_t           addr_q;
  logic [DivW-1:0] div_q;
  sample_t         buf_q;
  logic            buf_valid_q;
  sample_t         sample_q;
  logic            req_q;
  logic            done_q;
  logic            en_q;
  logic            underrun_q;

  logic counting;
  logic tick;

  assign counting = (state_q == StFetch) || (state_q == StWait) || (state_q == StDrain);
  assign tick     = counting && (div_q == DivLast);

  // Playback FSM, sample-rate divider, one-entry prefetch buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      stop_q      <= '0;
      addr_q      <= '0;
      div_q       <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      sample_q    <= IDLE_LEVEL;
      req_q       <= 1'b0;
      done_q      <= 1'b0;
      en_q        <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (counting) begin
        div_q <= tick ? '0 : div_q + DivW'(1);
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            underrun_q <= 1'b0;
            en_q       <= 1'b1;
            state_q    <= StArm;
          end
        end

        StArm: begin
          // stopPos is only valid from this cycle on
          stop_q      <= stopPos;
          addr_q      <= BASE_ADDR;
          div_q       <= '0;
          buf_valid_q <= 1'b0;
          if (stopPos <= BASE_ADDR) begin
            en_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            req_q   <= 1'b1;
            state_q <= StFetch;
          end
        end

        StFetch, StWait: begin
          if (state_q == StFetch && mem.data_ready) begin
            buf_q       <= mem.mem_data;
            buf_valid_q <= 1'b1;
            addr_q      <= addr_q + addr_t'(1);
            req_q       <= 1'b0;
            state_q     <= StWait;
          end
          // A tick with an empty buffer holds the current sample; any fetch keeps going.
          if (tick) begin
            if (buf_valid_q) begin
              sample_q    <= buf_q;
              buf_valid_q <= 1'b0;
              if (addr_q < stop_q) begin
                req_q   <= 1'b1;
                state_q <= StFetch;
              end else begin
                state_q <= StDrain;
              end
            end else begin
              underrun_q <= 1'b1;
            end
          end
        end

        StDrain: begin
          if (tick) begin
            en_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end

        StDone: begin
          sample_q <= IDLE_LEVEL;
          state_q  <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem.audio_req  = req_q;
  assign mem.audio_addr = addr_q;
  assign audio_done     = done_q;
  assign audio_en       = en_q;
  assign underrun       = underrun_q;

  pwm_dac #(
    .IDLE_LEVEL(IDLE_LEVEL)
  ) u_pwm_dac (
    .clk   (clk),
    .clr   (clr),
    .sample(sample_q),
    .pwm   (audio_pwm)
  );

endmodule
